uart_frame_loader: RTL and testbench

- Sits between UART_Rx and image_memory; replaces the free-running write-address counter and Pixel_Compiler pairing on the store path.
- Detects a 2-byte start-of-frame sync, packs byte pairs into 12-bit RGB444 pixels, and drives BRAM write strobe, address and data.
- Checks an XOR checksum, enforces an inter-byte timeout, and reports frame_done / frame_error to LEDs and to the display gating logic.

---
 rtl/image_pkg.sv | 23 ++
 rtl/byte_timeout_counter.sv | 39 +++
 rtl/uart_frame_loader.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants for the image store path: default image geometry, BRAM
// address width, loader FSM state encoding and loader error codes.
package image_pkg;

  localparam int unsigned IMG_WIDTH  = 320;
  localparam int unsigned IMG_HEIGHT = 240;
  localparam int unsigned IMG_SIZE   = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned ADDR_WIDTH = 17;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    PIX_HI = 3'd2,
    PIX_LO = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

endpackage

// File: rtl/byte_timeout_counter.sv
// Saturating idle-cycle counter for UART-fed loaders.
// Ports:
//   clk_100MHz - system clock
//   reset      - asynchronous, active-high
//   clear      - synchronous clear (wins over enable)
//   enable     - count one cycle while high
//   expired    - count has reached LIMIT (held until clear)
module byte_timeout_counter #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_C)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/uart_frame_loader.sv
// Frame loader between UART_Rx and image_memory. Hunts for a two-byte sync,
// packs byte pairs into RGB444 pixels written to BRAM, checks an XOR checksum
// and enforces an inter-byte timeout.
// Ports:
//   clk_100MHz, reset        - clock, asynchronous active-high reset
//   rx_valid, rx_byte        - byte strobe and data from UART_Rx
//   load_enable              - store mode; dropping it mid-frame aborts
//   wr_en, wr_addr, wr_data  - BRAM write port (one strobe per pixel)
//   busy                     - frame reception in progress
//   frame_done, frame_error  - sticky result of the last frame attempt
//   err_code                 - 00 none, 01 timeout, 10 checksum, 11 abort
module uart_frame_loader
  import image_pkg::*;
#(
  parameter int unsigned WIDTH          = IMG_WIDTH,
  parameter int unsigned HEIGHT         = IMG_HEIGHT,
  parameter int unsigned ADDR_WIDTH     = image_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  load_enable,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [1:0]            err_code
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

  state_t                state_q, state_d;
  logic                  accept;
  logic                  abort;
  logic                  timed_out;
  logic                  tmo_clear;
  logic                  tmo_expired;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           data_q, data_d;
  logic [3:0]            red_q, red_d;
  logic [7:0]            csum_q, csum_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_q, err_d;

  assign accept    = rx_valid & load_enable;
  assign busy      = (state_q != IDLE);
  // Busy implies load_enable was high when the frame started, so a low level
  // here is the falling edge seen one cycle late at most.
  assign abort     = busy & ~load_enable;
  assign timed_out = busy & tmo_expired;

  // State register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort || timed_out) begin
      state_d = IDLE;
    end else if (accept) begin
      unique case (state_q)
        IDLE:    if (rx_byte == SYNC0) state_d = SYNC;
        SYNC: begin
          if (rx_byte == SYNC1)      state_d = PIX_HI;
          else if (rx_byte == SYNC0) state_d = SYNC;
          else                       state_d = IDLE;
        end
        PIX_HI:  state_d = PIX_LO;
        PIX_LO:  state_d = (addr_q == LAST_ADDR) ? CHECK : PIX_HI;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    red_d   = red_q;
    csum_d  = csum_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;

    // Address advances the cycle after a write; it parks on the last pixel.
    if (wr_en_q && (addr_q != LAST_ADDR)) addr_d = addr_q + ADDR_WIDTH'(1);

    if (abort) begin
      error_d = 1'b1;
      err_d   = ERR_ABORT;
    end else if (timed_out) begin
      error_d = 1'b1;
      err_d   = ERR_TIMEOUT;
    end else if (accept) begin
      unique case (state_q)
        SYNC: begin
          if (rx_byte == SYNC1) begin
            addr_d  = '0;
            csum_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            err_d   = ERR_NONE;
          end
        end
        PIX_HI: begin
          red_d  = rx_byte[3:0];
          csum_d = csum_q ^ rx_byte;
        end
        PIX_LO: begin
          csum_d  = csum_q ^ rx_byte;
          wr_en_d = 1'b1;
          data_d  = {red_q, rx_byte};
        end
        CHECK: begin
          if (rx_byte == csum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
            err_d   = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      red_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      red_q   <= red_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  // Idle clocks are counted only while a frame is in flight.
  assign tmo_clear = accept | (state_d != state_q);

  byte_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (tmo_clear),
    .enable     (busy),
    .expired    (tmo_expired)
  );

  assign wr_en       = wr_en_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign frame_done  = done_q;
  assign frame_error = error_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader on a 2x2 image with a short timeout.
// Expected BRAM writes are queued when the second byte of each pixel is sent
// and checked (address, data, arrival cycle) as the DUT issues them.
module tb_uart_frame_loader;

  localparam int unsigned W  = 2;
  localparam int unsigned H  = 2;
  localparam int unsigned TO = 50;
  localparam int unsigned AW = 17;

  logic          clk_100MHz = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          load_enable = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_error;
  logic [1:0]    err_code;

  uart_frame_loader #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO),
    .SYNC0          (8'hA5),
    .SYNC1          (8'h5A)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .load_enable (load_enable),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .err_code    (err_code)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   data;
    int            at;
  } wr_t;

  wr_t exp_q[$];
  wr_t got;
  int  compared = 0;
  int  mismatched = 0;

  logic [7:0] pix [8] = '{8'h0F, 8'h12, 8'h03, 8'h45, 8'h0A, 8'hBC, 8'h01, 8'hFF};
  logic [7:0] good_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Write scoreboard
  always @(negedge clk_100MHz) begin
    if (wr_en === 1'b1) begin
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_write: observed addr %0h data %0h, expected no write",
               wr_addr, wr_data);
      end
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(got.addr));
        chk("wr_data", 32'(wr_data), 32'(got.data));
        chk("wr_latency", cyc, got.at);
      end
    end
  end

  // Bytes are driven on the falling edge and sampled on the next rising
  // edge; the write strobe must be visible right after that rising edge.
  task automatic send_byte(input logic [7:0] b, input bit push,
                           input logic [AW-1:0] a, input logic [11:0] d);
    @(negedge clk_100MHz);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (push) exp_q.push_back('{addr: a, data: d, at: cyc + 1});
    @(negedge clk_100MHz);
    rx_valid = 1'b0;
    repeat (8) @(negedge clk_100MHz);
  endtask

  task automatic send_pixel(input int i, input bit push);
    send_byte(pix[2*i], 1'b0, '0, '0);
    send_byte(pix[2*i+1], push, AW'(i), {pix[2*i][3:0], pix[2*i+1]});
  endtask

  task automatic send_frame(input logic [7:0] cs);
    send_byte(8'hA5, 1'b0, '0, '0);
    send_byte(8'h5A, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) send_pixel(i, 1'b1);
    send_byte(cs, 1'b0, '0, '0);
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic chk_flags(input logic d, input logic e, input logic [1:0] c);
    chk("busy", 32'(busy), 32'(0));
    chk("frame_done", 32'(frame_done), 32'(d));
    chk("frame_error", 32'(frame_error), 32'(e));
    chk("err_code", 32'(err_code), 32'(c));
    chk("writes_drained", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(0));
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
    chk({tag, "_wr_data"}, 32'(wr_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, "_frame_error"}, 32'(frame_error), 32'(0));
    chk({tag, "_err_code"}, 32'(err_code), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // XOR of the eight pixel bytes (8'h13 for this table)
    good_cs = 8'h00;
    for (int i = 0; i < 8; i++) good_cs = good_cs ^ pix[i];

    // Reset state
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);

    // Good frame
    send_frame(good_cs);
    chk_flags(1'b1, 1'b0, 2'b00);

    // Bad checksum: all four pixels still land
    send_frame(8'h00);
    chk_flags(1'b0, 1'b1, 2'b10);

    // Sync hunting: 33 A5 A5 5A ...
    send_byte(8'h33, 1'b0, '0, '0);
    send_byte(8'hA5, 1'b0, '0, '0);
    send_frame(good_cs);
    chk_flags(1'b1, 1'b0, 2'b00);

    // Stray byte between sync bytes: everything after is ignored
    send_byte(8'hA5, 1'b0, '0, '0);
    send_byte(8'h00, 1'b0, '0, '0);
    send_byte(8'h5A, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) send_pixel(i, 1'b0);
    send_byte(good_cs, 1'b0, '0, '0);
    chk_flags(1'b1, 1'b0, 2'b00);

    // Timeout after one byte of the first pixel
    send_byte(8'hA5, 1'b0, '0, '0);
    send_byte(8'h5A, 1'b0, '0, '0);
    send_byte(pix[0], 1'b0, '0, '0);
    chk("busy_before_timeout", 32'(busy), 32'(1));
    repeat (60) @(negedge clk_100MHz);
    chk_flags(1'b0, 1'b1, 2'b01);
    send_frame(good_cs);
    chk_flags(1'b1, 1'b0, 2'b00);

    // Abort after three pixels
    send_byte(8'hA5, 1'b0, '0, '0);
    send_byte(8'h5A, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) send_pixel(i, 1'b1);
    load_enable = 1'b0;
    @(negedge clk_100MHz);
    chk_flags(1'b0, 1'b1, 2'b11);
    send_pixel(3, 1'b0);
    send_byte(good_cs, 1'b0, '0, '0);
    chk_flags(1'b0, 1'b1, 2'b11);
    load_enable = 1'b1;

    // Reset mid-frame clears outputs immediately, without flagging the frame
    send_byte(8'hA5, 1'b0, '0, '0);
    send_byte(8'h5A, 1'b0, '0, '0);
    send_pixel(0, 1'b1);
    chk("busy_mid_frame", 32'(busy), 32'(1));
    chk("wr_addr_mid_frame", 32'(wr_addr), 32'(1));
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    chk_all_zero("after_reset");
    chk("writes_drained_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
